aes_decrypt_iter: RTL and testbench

//  Iterative AES-128 inverse cipher (FIPS-197 §5.3): recovers plain text from cypher text with a precomputed
//  1408-bit expanded key. One inverse round per clock, start/done handshake. Consumes the expand_key schedule
//  and sits beside the encrypt path as the receive-side counterpart.

---
 rtl/aes_decrypt_iter_if.sv | 30 +++
 rtl/aes_decrypt_iter.sv | 217 +++++++++++++++++++++
 tb/tb_aes_decrypt_iter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_decrypt_iter_if.sv
// -----------------------------------------------------------------------------
// aes_decrypt_iter_if
// Handshake and data bundle for the iterative AES-128 inverse cipher.
//   start         master->slave  request, honoured only while ready=1
//   expanded_key  master->slave  11 round keys, rk0 in the top 128 bits
//   cypher_text   master->slave  block to decrypt, byte0 = [127:120]
//   ready         slave->master  core idle, start will be accepted
//   done          slave->master  one-cycle pulse, plain_text valid
//   plain_text    slave->master  result, held until the next done
// -----------------------------------------------------------------------------
interface aes_decrypt_iter_if #(
    parameter int KEY_W = 1408
);
    logic             start;
    logic [KEY_W-1:0] expanded_key;
    logic [127:0]     cypher_text;
    logic             ready;
    logic             done;
    logic [127:0]     plain_text;

    modport master (
        output start, expanded_key, cypher_text,
        input  ready, done, plain_text
    );

    modport slave (
        input  start, expanded_key, cypher_text,
        output ready, done, plain_text
    );
endinterface

// File: rtl/aes_decrypt_iter.sv
// -----------------------------------------------------------------------------
// aes_decrypt_iter
// Iterative AES-128 inverse cipher, one inverse round per clock.
// Accept edge loads cypher_text ^ rk10, nine full inverse rounds follow
// (rk9..rk1), and the final round (no InvMixColumns, rk0) writes plain_text
// and pulses done. Latency from accept edge to done is 10 cycles.
// Ports:
//   clk    in  single clock, posedge
//   rst_n  in  synchronous active-low reset
//   bus    aes_decrypt_iter_if.slave (start/expanded_key/cypher_text in,
//          ready/done/plain_text out)
// Optional feature, macro AES_DEC_ROUND_OBS_EN:
//   round_state out [127:0] state register
//   round_idx   out [3:0]   10 after load, 9..1 per round, 0 after final,
//                           15 when idle
// -----------------------------------------------------------------------------
module aes_decrypt_iter #(
    parameter int NR    = 10,
    parameter int KEY_W = (NR + 1) * 128
) (
    input  logic                clk,
    input  logic                rst_n,
    aes_decrypt_iter_if.slave   bus
`ifdef AES_DEC_ROUND_OBS_EN
    ,
    output logic [127:0]        round_state,
    output logic [3:0]          round_idx
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2
    } fsm_t;

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [10:0] base;
        base = 11'd2047 - {b, 3'b000};
        return INV_SBOX[base -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by one of the InvMixColumns coefficients via an xtime chain.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] x2, x4, x8, r;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (c)
            4'h9:    r = x8 ^ a;
            4'hb:    r = x8 ^ x2 ^ a;
            4'hd:    r = x8 ^ x4 ^ a;
            4'he:    r = x8 ^ x4 ^ x2;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
                gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
                gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
                gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
    endfunction

    // Row r rotates right by r: output byte 4c+r takes input byte 4((c-r) mod 4)+r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        return {s[127:120], s[23:16],   s[47:40],   s[71:64],
                s[95:88],   s[119:112], s[15:8],    s[39:32],
                s[63:56],   s[87:80],   s[111:104], s[7:0],
                s[31:24],   s[55:48],   s[79:72],   s[103:96]};
    endfunction

    fsm_t         fsm_r, fsm_nxt_s;
    logic [127:0] state_r, state_nxt_s;
    logic [3:0]   rnd_r, rnd_nxt_s;
    logic [127:0] pt_r, pt_nxt_s;
    logic         done_r, done_nxt_s;
    logic         ready_r, ready_nxt_s;

    logic [127:0] shift_s, sub_s, rk_s, addk_s, mix_s, load_s;
    logic [10:0]  rk_base_s;

    // rnd_r reaches 0 on entry to the final round, so the same selector yields rk0 there.
    assign rk_base_s = 11'(KEY_W - 1) - {rnd_r, 7'b0000000};
    assign rk_s      = bus.expanded_key[rk_base_s -: 128];
    assign load_s    = bus.cypher_text ^ bus.expanded_key[127:0];
    assign shift_s   = inv_shift_rows(state_r);
    assign addk_s    = sub_s ^ rk_s;

    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sub_s[127 - 8*i -: 8] = inv_sbox(shift_s[127 - 8*i -: 8]);
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mix_s[127 - 32*c -: 32] = inv_mix_col(addk_s[127 - 32*c -: 32]);
    end

    // Next-state and next-register values for the round sequencer.
    always_comb begin
        fsm_nxt_s   = fsm_r;
        state_nxt_s = state_r;
        rnd_nxt_s   = rnd_r;
        pt_nxt_s    = pt_r;
        done_nxt_s  = 1'b0;
        ready_nxt_s = ready_r;
        case (fsm_r)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = load_s;
                    rnd_nxt_s   = 4'(NR - 1);
                    ready_nxt_s = 1'b0;
                    fsm_nxt_s   = S_ROUND;
                end else begin
                    ready_nxt_s = 1'b1;
                    fsm_nxt_s   = S_IDLE;
                end
            end
            S_ROUND: begin
                state_nxt_s = mix_s;
                rnd_nxt_s   = rnd_r - 4'd1;
                if (rnd_r == 4'd1) begin
                    fsm_nxt_s = S_FINAL;
                end else begin
                    fsm_nxt_s = S_ROUND;
                end
            end
            S_FINAL: begin
                pt_nxt_s    = addk_s;
                done_nxt_s  = 1'b1;
                ready_nxt_s = 1'b1;
                fsm_nxt_s   = S_IDLE;
            end
            default: begin
                fsm_nxt_s   = S_IDLE;
                ready_nxt_s = 1'b1;
            end
        endcase
    end

    // Sequencer and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_r   <= S_IDLE;
            state_r <= 128'd0;
            rnd_r   <= 4'd0;
            pt_r    <= 128'd0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            fsm_r   <= fsm_nxt_s;
            state_r <= state_nxt_s;
            rnd_r   <= rnd_nxt_s;
            pt_r    <= pt_nxt_s;
            done_r  <= done_nxt_s;
            ready_r <= ready_nxt_s;
        end
    end

    assign bus.ready      = ready_r;
    assign bus.done       = done_r;
    assign bus.plain_text = pt_r;

`ifdef AES_DEC_ROUND_OBS_EN
    logic [3:0] idx_r, idx_nxt_s;

    // Index of the round key most recently folded into the state.
    always_comb begin
        idx_nxt_s = idx_r;
        case (fsm_r)
            S_IDLE: begin
                if (bus.start) begin
                    idx_nxt_s = 4'd10;
                end else begin
                    idx_nxt_s = 4'd15;
                end
            end
            S_ROUND: idx_nxt_s = rnd_r;
            S_FINAL: idx_nxt_s = 4'd0;
            default: idx_nxt_s = 4'd15;
        endcase
    end

    // Observation index register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_r <= 4'd15;
        end else begin
            idx_r <= idx_nxt_s;
        end
    end

    assign round_state = state_r;
    assign round_idx   = idx_r;
`endif

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_decrypt_iter
// Directed bench for aes_decrypt_iter using the FIPS-197 C.1 and App.B
// vectors with their published round-key schedules.
// -----------------------------------------------------------------------------
module tb_aes_decrypt_iter;

    localparam logic [1407:0] EK1 = {
        128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;

    localparam logic [1407:0] EK2 = {
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    aes_decrypt_iter_if #(.KEY_W(1408)) bus ();

`ifdef AES_DEC_ROUND_OBS_EN
    logic [127:0] round_state;
    logic [3:0]   round_idx;
`endif

    aes_decrypt_iter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus)
`ifdef AES_DEC_ROUND_OBS_EN
        ,
        .round_state (round_state),
        .round_idx   (round_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Single block: accept, wait for done, verify latency, result and hold.
    task automatic do_op(input logic [1407:0] ek, input logic [127:0] ct,
                         input logic [127:0] exp, input string tag);
        int c;
        @(negedge clk);
        check({tag, "_ready_pre"}, 128'(bus.ready), 128'd1);
        bus.expanded_key = ek;
        bus.cypher_text  = ct;
        bus.start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        c = 0;
        while (!bus.done && c < 20) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_latency"}, 128'(c), 128'd10);
        check({tag, "_pt"}, bus.plain_text, exp);
        check({tag, "_ready_done"}, 128'(bus.ready), 128'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 128'(bus.done), 128'd0);
        check({tag, "_pt_hold"}, bus.plain_text, exp);
    endtask

    initial begin
        int n_low;
        int n_done;
        int first_done;
        int second_done;
        n_checks         = 0;
        n_errors         = 0;
        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.expanded_key = '0;
        bus.cypher_text  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 128'(bus.ready), 128'd1);
        check("rst_done", 128'(bus.done), 128'd0);
        check("rst_pt", bus.plain_text, 128'd0);
`ifdef AES_DEC_ROUND_OBS_EN
        check("rst_round_state", round_state, 128'd0);
        check("rst_round_idx", 128'(round_idx), 128'd15);
`endif
        rst_n = 1'b1;

        do_op(EK1, CT1, PT1, "t1");
        do_op(EK2, CT2, PT2, "t2");

        // Back-to-back: start held high, second block accepted in the done cycle.
        @(negedge clk);
        bus.expanded_key = EK1;
        bus.cypher_text  = CT1;
        bus.start        = 1'b1;
        @(posedge clk);
        n_low       = 0;
        n_done      = 0;
        first_done  = -1;
        second_done = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!bus.ready) n_low++;
            if (bus.done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = c;
                    check("t3_pt1", bus.plain_text, PT1);
                    bus.expanded_key = EK2;
                    bus.cypher_text  = CT2;
                end else begin
                    second_done = c;
                    check("t3_pt2", bus.plain_text, PT2);
                    bus.start = 1'b0;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        check("t3_done_count", 128'(n_done), 128'd2);
        check("t3_first_done", 128'(first_done), 128'd10);
        check("t3_done_spacing", 128'(second_done - first_done), 128'd11);
        check("t3_ready_low", 128'(n_low), 128'd20);

        // Busy start: start pulses and changed cypher_text mid-operation are ignored.
        @(negedge clk);
        bus.expanded_key = EK1;
        bus.cypher_text  = CT1;
        bus.start        = 1'b1;
        @(posedge clk);
        n_done     = 0;
        first_done = -1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                if (first_done < 0) first_done = c;
                check("t4_pt", bus.plain_text, PT1);
            end
            if (c >= 3 && c <= 7) begin
                bus.start       = 1'b1;
                bus.cypher_text = CT2 ^ 128'(c);
            end else begin
                bus.start = 1'b0;
            end
        end
        check("t4_done_count", 128'(n_done), 128'd1);
        check("t4_latency", 128'(first_done), 128'd10);

        // Mid-operation reset: abort with reset outputs and no done pulse.
        @(negedge clk);
        bus.expanded_key = EK1;
        bus.cypher_text  = CT1;
        bus.start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_ready", 128'(bus.ready), 128'd1);
        check("t5_done", 128'(bus.done), 128'd0);
        check("t5_pt", bus.plain_text, 128'd0);
        rst_n  = 1'b1;
        n_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("t5_no_done", 128'(n_done), 128'd0);
        do_op(EK1, CT1, PT1, "t5_fresh");

`ifdef AES_DEC_ROUND_OBS_EN
        // Observation ports across one C.1 block.
        @(negedge clk);
        bus.expanded_key = EK1;
        bus.cypher_text  = CT1;
        bus.start        = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) begin
                bus.start = 1'b0;
                check("t6_load_state", round_state, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
            end
            if (c <= 9) begin
                check("t6_idx", 128'(round_idx), 128'(10 - c));
            end else if (c == 10) begin
                check("t6_idx_final", 128'(round_idx), 128'd0);
                check("t6_pt", bus.plain_text, PT1);
            end else begin
                check("t6_idx_idle", 128'(round_idx), 128'd15);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
